// File: rtl/lc3_mem_arb.sv
// lc3_mem_arb: shares the single-port LC-3 RAM between fetch (m0) and load/store (m1).
// Define LC3_MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module lc3_mem_arb #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_ack,
   output logic                  m0_err,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_ack,
   output logic                  m1_err,
   output logic [DATA_WIDTH-1:0] m_rdata,
   output logic                  mem_cs,
   output logic                  mem_r_w,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t     state;
   logic       gnt;
   logic       pick;
   logic [7:0] cnt;
   logic [7:0] cnt_nxt;

   assign cnt_nxt = cnt + 8'd1;

`ifdef LC3_MEM_ARB_RR_EN
   logic last;

   // On a tie the port that did not win last time is chosen.
   always_comb begin
      pick = 1'b0;
      if (m0_req && m1_req)
         pick = ~last;
      else
         pick = ~m0_req;
   end

   always_ff @(posedge clk) begin
      if (reset)
         last <= 1'b1;
      else if (state == ISSUE)
         last <= gnt;
   end
`else
   always_comb begin
      pick = ~m0_req;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         cnt       <= 8'd0;
         mem_cs    <= 1'b0;
         mem_r_w   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         m_rdata   <= '0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         m0_err    <= 1'b0;
         m1_err    <= 1'b0;
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         m0_err <= 1'b0;
         m1_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  gnt       <= pick;
                  mem_cs    <= 1'b1;
                  mem_r_w   <= pick ? m1_we : m0_we;
                  mem_addr  <= pick ? m1_addr : m0_addr;
                  mem_wdata <= pick ? m1_wdata : m0_wdata;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               mem_cs  <= 1'b0;
               mem_r_w <= 1'b0;
               cnt     <= 8'd0;
               state   <= WAIT;
            end
            WAIT: begin
               if (mem_ready) begin
                  m_rdata <= mem_rdata;
                  m0_ack  <= ~gnt;
                  m1_ack  <= gnt;
                  state   <= DONE;
               end else begin
                  cnt <= cnt_nxt;
                  // Timed-out reads return zero so a stale word is never consumed.
                  if (cnt_nxt == TMO) begin
                     m_rdata <= '0;
                     m0_ack  <= ~gnt;
                     m1_ack  <= gnt;
                     m0_err  <= ~gnt;
                     m1_err  <= gnt;
                     state   <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
